// File: rtl/matmul2x2_pcpi_seq.sv
// PCPI coprocessor computing C = A x B for 2x2 matrices of unsigned nibbles.
// A single external 4x4 combinational multiplier is reused over eight steps.
// Each pair of partial products is summed and saturated to 8 bits.
module matmul2x2_pcpi_seq #(
  parameter logic [6:0] OPCODE = 7'b0001011,
  parameter logic [2:0] FUNCT3 = 3'b000,
  parameter logic [6:0] FUNCT7 = 7'b0000001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_ready,
  output logic        pcpi_wr,
  output logic        pcpi_wait,
  output logic [31:0] pcpi_rd,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_p,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL, DONE, HOLD} state_t;

  state_t          state;
  state_t          state_next;
  logic [2:0]      step;
  logic [8:0]      acc;
  logic [15:0]     a_mat;
  logic [15:0]     b_mat;
  logic [3:0][7:0] c_mat;
  logic            match;
  logic            row_i;
  logic            col_j;
  logic            term_t;
  logic [9:0]      sum;
  logic [7:0]      sum_sat;
  logic            unused_bits;

  // Instruction decode and step-field split used by both the datapath and outputs.
  assign match   = pcpi_valid
                   && (pcpi_insn[6:0]   == OPCODE)
                   && (pcpi_insn[14:12] == FUNCT3)
                   && (pcpi_insn[31:25] == FUNCT7);
  assign row_i   = step[2];
  assign col_j   = step[1];
  assign term_t  = step[0];
  assign sum     = {1'b0, acc} + {2'b00, mul_p};
  assign sum_sat = (sum > 10'd255) ? 8'hFF : sum[7:0];

  // Operand bits that play no part in the computation are collected here on purpose.
  assign unused_bits = ^{pcpi_rs1[31:16], pcpi_rs2[31:16], pcpi_insn[24:15], pcpi_insn[11:7]};

  // State register; synchronous reset returns to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: a dropped valid aborts MUL, HOLD waits for valid to fall.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (match) state_next = MUL;
      MUL: begin
        if (!pcpi_valid)        state_next = IDLE;
        else if (step == 3'd7)  state_next = DONE;
      end
      DONE: state_next = HOLD;
      HOLD: if (!pcpi_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands, step the counter, accumulate and store saturated sums.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step  <= 3'd0;
      acc   <= 9'd0;
      a_mat <= 16'd0;
      b_mat <= 16'd0;
      c_mat <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (match) begin
            a_mat <= pcpi_rs1[15:0];
            b_mat <= pcpi_rs2[15:0];
            step  <= 3'd0;
            acc   <= 9'd0;
          end
        end
        MUL: begin
          if (pcpi_valid) begin
            step <= step + 3'd1;
            if (!term_t) begin
              acc <= {1'b0, mul_p};
            end else begin
              c_mat[{row_i, col_j}] <= sum_sat;
              acc                   <= 9'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from state; everything reads zero while reset is held.
  always_comb begin
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_rd    = 32'd0;
    mul_a      = 4'd0;
    mul_b      = 4'd0;
    busy       = 1'b0;
    pcpi_wait  = rst_n && match && ((state == IDLE) || (state == MUL));
    case (state)
      MUL: begin
        mul_a = a_mat[{row_i, term_t, 2'b00} +: 4];
        mul_b = b_mat[{term_t, col_j, 2'b00} +: 4];
        busy  = 1'b1;
      end
      DONE: begin
        pcpi_ready = 1'b1;
        pcpi_wr    = 1'b1;
        pcpi_rd    = c_mat;
        busy       = 1'b1;
      end
      HOLD: busy = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_matmul2x2_pcpi_seq.sv
// Self-checking bench for matmul2x2_pcpi_seq: directed table, corner sequences
// and random operands compared against a plain-arithmetic matrix model.
module tb_matmul2x2_pcpi_seq;

  localparam logic [31:0] INSN_MM    = {7'b0000001, 10'd0, 3'b000, 5'd0, 7'b0001011};
  localparam logic [31:0] INSN_OTHER = {7'b0000001, 10'd0, 3'b000, 5'd0, 7'b0110011};

  logic        clk;
  logic        rst_n;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_ready;
  logic        pcpi_wr;
  logic        pcpi_wait;
  logic [31:0] pcpi_rd;
  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic [7:0]  mul_p;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] mulSeqA [8];
  logic [3:0] mulSeqB [8];

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] expRd;
    int          hold;
  } vec_t;

  vec_t vecs [5];

  matmul2x2_pcpi_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_rs1   (pcpi_rs1),
    .pcpi_rs2   (pcpi_rs2),
    .pcpi_ready (pcpi_ready),
    .pcpi_wr    (pcpi_wr),
    .pcpi_wait  (pcpi_wait),
    .pcpi_rd    (pcpi_rd),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_p      (mul_p),
    .busy       (busy)
  );

  // External shared multiplier.
  assign mul_p = 8'(mul_a) * 8'(mul_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog in case something stalls unexpectedly.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: C[i][j] = sat8(sum_k A[i][k]*B[k][j]), elements packed row-major by nibble.
  function automatic logic [31:0] refMatmul(input logic [15:0] a, input logic [15:0] b);
    int am [2][2];
    int bm [2][2];
    int s;
    logic [31:0] res;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        am[r][c] = int'(a[(r*2 + c)*4 +: 4]);
        bm[r][c] = int'(b[(r*2 + c)*4 +: 4]);
      end
    res = 32'd0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        s = am[r][0]*bm[0][c] + am[r][1]*bm[1][c];
        if (s > 255) s = 255;
        res[(r*2 + c)*8 +: 8] = 8'(s);
      end
    return res;
  endfunction

  // Count how many of the eight recorded operand pairs differ from A[i][t], B[t][j].
  function automatic int mulSeqErrors(input logic [15:0] a, input logic [15:0] b);
    int errs;
    int i, j, t;
    errs = 0;
    for (int s = 0; s < 8; s++) begin
      i = s / 4;
      j = (s / 2) % 2;
      t = s % 2;
      if (mulSeqA[s] !== a[(i*2 + t)*4 +: 4]) errs++;
      if (mulSeqB[s] !== b[(t*2 + j)*4 +: 4]) errs++;
    end
    return errs;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one matching request from IDLE, holding valid 'hold' cycles past ready.
  task automatic applyStimulus(input logic [31:0] rs1, input logic [31:0] rs2, input int hold,
                               output logic [31:0] rd, output int readyAt, output int readyCnt,
                               output int protoErr);
    int lastBusy;
    lastBusy = (9 + hold > 10) ? 9 + hold : 10;
    pcpi_insn  = INSN_MM;
    pcpi_rs1   = rs1;
    pcpi_rs2   = rs2;
    pcpi_valid = 1'b1;
    rd = 32'd0; readyAt = -1; readyCnt = 0; protoErr = 0;
    #1;
    if (pcpi_wait !== 1'b1 || pcpi_ready !== 1'b0 || busy !== 1'b0) protoErr++;
    for (int cyc = 1; cyc <= 12 + hold; cyc++) begin
      @(posedge clk); #1;
      pcpi_rs1 = $urandom;
      pcpi_rs2 = $urandom;
      if (pcpi_ready === 1'b1) begin
        readyCnt++;
        readyAt = cyc;
        rd = pcpi_rd;
      end
      if (pcpi_wait !== (cyc <= 8)) protoErr++;
      if (busy !== (cyc <= lastBusy)) protoErr++;
      if (pcpi_wr !== (cyc == 9)) protoErr++;
      if (cyc != 9 && pcpi_rd !== 32'd0) protoErr++;
      if (cyc <= 8) begin
        mulSeqA[cyc-1] = mul_a;
        mulSeqB[cyc-1] = mul_b;
      end else if (mul_a !== 4'd0 || mul_b !== 4'd0) begin
        protoErr++;
      end
      if (cyc == 9 + hold) pcpi_valid = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] r1;
    logic [31:0] r2;
    int readyAt, readyCnt, protoErr, errs, hold;

    vecs[0] = '{rs1: 32'h0000_1001, rs2: 32'h0000_4321, expRd: 32'h0403_0201, hold: 0};
    vecs[1] = '{rs1: 32'hDEAD_4321, rs2: 32'hBEEF_4321, expRd: 32'h160F_0A07, hold: 0};
    vecs[2] = '{rs1: 32'h0000_FFFF, rs2: 32'h0000_FFFF, expRd: 32'hFFFF_FFFF, hold: 1};
    vecs[3] = '{rs1: 32'h0000_006E, rs2: 32'h0000_0A0E, expRd: 32'h0000_00FF, hold: 0};
    vecs[4] = '{rs1: 32'h0000_1001, rs2: 32'h0000_FFFF, expRd: 32'h0F0F_0F0F, hold: 5};

    rst_n = 1'b0; pcpi_valid = 1'b0; pcpi_insn = 32'd0; pcpi_rs1 = 32'd0; pcpi_rs2 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs",
                {pcpi_ready, pcpi_wr, pcpi_wait, busy, mul_a, mul_b, 20'd0} | pcpi_rd, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed table");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].rs1, vecs[i].rs2, vecs[i].hold, rd, readyAt, readyCnt, protoErr);
      checkOutput($sformatf("tbl%0d_rd", i), rd, vecs[i].expRd);
      checkOutput($sformatf("tbl%0d_ready_at", i), readyAt, 32'd9);
      checkOutput($sformatf("tbl%0d_ready_cnt", i), readyCnt, 32'd1);
      checkOutput($sformatf("tbl%0d_protocol", i), protoErr, 32'd0);
      if (i == 1) begin
        checkOutput("tbl1_step0_mul", {mulSeqA[0], mulSeqB[0]}, 32'h11);
        checkOutput("tbl1_step1_mul", {mulSeqA[1], mulSeqB[1]}, 32'h23);
      end
    end

    $display("[TB] non-matching opcode");
    pcpi_insn = INSN_OTHER; pcpi_rs1 = 32'h4321; pcpi_rs2 = 32'h4321; pcpi_valid = 1'b1;
    #1;
    errs = 0;
    for (int c = 0; c < 20; c++) begin
      if (pcpi_wait !== 1'b0 || pcpi_ready !== 1'b0 || busy !== 1'b0 ||
          mul_a !== 4'd0 || mul_b !== 4'd0) errs++;
      @(posedge clk); #1;
    end
    checkOutput("nonmatch_quiet", errs, 32'd0);
    pcpi_valid = 1'b0;
    @(posedge clk); #1;

    $display("[TB] abort at step 3");
    pcpi_insn = INSN_MM; pcpi_rs1 = 32'hFFFF; pcpi_rs2 = 32'hFFFF; pcpi_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 4) pcpi_valid = 1'b0;
    end
    @(posedge clk); #1;
    checkOutput("abort_idle", {busy, pcpi_ready, pcpi_wait}, 32'd0);
    errs = 0;
    for (int c = 0; c < 12; c++) begin
      if (pcpi_ready !== 1'b0) errs++;
      @(posedge clk); #1;
    end
    checkOutput("abort_no_ready", errs, 32'd0);
    applyStimulus(32'h4321, 32'h4321, 1, rd, readyAt, readyCnt, protoErr);
    checkOutput("after_abort_rd", rd, 32'h160F_0A07);
    checkOutput("after_abort_ready_at", readyAt, 32'd9);

    $display("[TB] reset at step 5");
    pcpi_insn = INSN_MM; pcpi_rs1 = 32'h4321; pcpi_rs2 = 32'hFFFF; pcpi_valid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 6) begin
        rst_n = 1'b0;
        pcpi_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    checkOutput("reset_mid_flags", {pcpi_ready, pcpi_wr, pcpi_wait, busy, mul_a, mul_b}, 32'd0);
    checkOutput("reset_mid_rd", pcpi_rd, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(32'h1001, 32'h4321, 0, rd, readyAt, readyCnt, protoErr);
    checkOutput("after_reset_rd", rd, 32'h0403_0201);
    checkOutput("after_reset_ready_cnt", readyCnt, 32'd1);

    $display("[TB] random operands");
    for (int n = 0; n < 16; n++) begin
      r1 = $urandom;
      r2 = $urandom;
      hold = $urandom_range(0, 3);
      applyStimulus(r1, r2, hold, rd, readyAt, readyCnt, protoErr);
      checkOutput($sformatf("rnd%0d_rd", n), rd, refMatmul(r1[15:0], r2[15:0]));
      checkOutput($sformatf("rnd%0d_ready_at", n), readyAt, 32'd9);
      checkOutput($sformatf("rnd%0d_protocol", n), protoErr, 32'd0);
      checkOutput($sformatf("rnd%0d_mul_seq", n), mulSeqErrors(r1[15:0], r2[15:0]), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matmul2x2_pcpi_seq.md
Name: matmul2x2_pcpi_seq

Overview:
- PCPI coprocessor controller for a 2x2 matrix product of unsigned 4-bit elements.
- Time-multiplexes one shared combinational 4x4 multiplier over 8 steps, accumulates, saturates, and returns the packed result on the PCPI handshake.
- Sits between the nibble-serial instruction loader (PCPI master side) and the array multiplier; it owns the multiplier's operand inputs.

Parameters:
- OPCODE, 7'b0001011, insn[6:0] value that selects this block
- FUNCT3, 3'b000, insn[14:12] match value
- FUNCT7, 7'b0000001, insn[31:25] match value

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- pcpi_valid  in  1  request valid from master
- pcpi_insn  in  32  instruction word
- pcpi_rs1  in  32  matrix A in [15:0]: a00=[3:0], a01=[7:4], a10=[11:8], a11=[15:12]; [31:16] ignored
- pcpi_rs2  in  32  matrix B, same packing as A
- pcpi_ready  out  1  result valid, one-cycle pulse
- pcpi_wr  out  1  write-back request, equals pcpi_ready
- pcpi_wait  out  1  busy indication to master
- pcpi_rd  out  32  {c11,c10,c01,c00}, 8 bits each
- mul_a  out  4  shared multiplier operand m
- mul_b  out  4  shared multiplier operand q
- mul_p  in  8  shared multiplier product (combinational, same cycle)
- busy  out  1  high in MUL, DONE and HOLD

Behaviour:
- Clock and reset: clock clk; reset rst_n, synchronous, active-low.
- Reset values: state=IDLE, step=0, acc=0, C regs=0. All outputs are 0: pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd, mul_a, mul_b, busy.
- match = pcpi_valid & insn[6:0]==OPCODE & insn[14:12]==FUNCT3 & insn[31:25]==FUNCT7.
- pcpi_wait = match & (state==IDLE | state==MUL). This is combinational, so the master sees wait in the same cycle it presents the instruction.
- States:
  - IDLE: on match, latch rs1[15:0] and rs2[15:0], clear step and acc, go to MUL.
  - MUL: step is a 3-bit counter, 0..7. Decode i=step[2], j=step[1], t=step[0].
    - Drive mul_a=A[i][t] and mul_b=B[t][j].
    - t=0: acc <= mul_p (9-bit).
    - t=1: C[i][j] <= sat8(acc+mul_p), and acc <= 0.
    - At step 7, go to DONE.
  - DONE: single cycle. pcpi_ready=1, pcpi_wr=1, pcpi_rd={C11,C10,C01,C00}. Go to HOLD.
  - HOLD: wait until pcpi_valid==0, then go to IDLE. No restart is allowed while the master still holds valid.
- Outside MUL: mul_a=0 and mul_b=0. pcpi_rd=0 in every cycle except DONE.
- Latency: match sampled at edge 0, MUL occupies cycles 1..8, pcpi_ready is high in cycle 9.
- Arithmetic: each product is <=225; each sum is <=450 and is held in a 9-bit accumulator.
- Saturation: sat8(x) = x>255 ? 8'hFF : x[7:0].
- Abort: pcpi_valid low in any MUL cycle returns the block to IDLE the next cycle. No ready pulse is issued and the C regs keep stale values.
- Non-matching instructions are ignored: no wait and no ready.
- Operand stability: rs1/rs2 changing after the latch do not affect the result.
- Reset asserted mid-operation forces IDLE and all-zero outputs at the next edge, overriding all other activity.

Test Plan:
1. rs1=16'h1001 (identity), rs2=16'h4321, valid held high -> pcpi_ready/pcpi_wr high exactly 9 cycles later for one cycle, pcpi_rd=32'h04030201; pcpi_wait high from cycle 0 to 8.
2. rs1=rs2=16'h4321 -> pcpi_rd=32'h160F0A07 (7, 10, 15, 22); mul_a/mul_b sequence at step 0 is 1/1 and at step 1 is 2/3.
3. rs1=rs2=16'hFFFF -> every element saturates from 450, pcpi_rd=32'hFFFFFFFF.
4. Opcode 7'b0110011 with valid high for 20 cycles -> pcpi_wait, pcpi_ready and busy stay 0; mul_a=mul_b=0.
5. Valid dropped at step 3 -> no ready pulse and IDLE next cycle; a new request with 16'h4321 operands then yields 32'h160F0A07.
6. Valid held 5 cycles past ready -> single ready pulse and busy stays high in HOLD. Separately, rst_n low at step 5 -> all outputs 0 next cycle and a subsequent request completes normally.
